// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Decode/issue and writeback bundle for the register scoreboard.
//               master = pipeline side, slave = scoreboard side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 7
);
  logic          issue_valid;
  logic [AW-1:0] issue_rs1;
  logic [AW-1:0] issue_rs2;
  logic          issue_use_rs1;
  logic          issue_use_rs2;
  logic          issue_we;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic          flush;
  logic          busy_rs1;
  logic          busy_rs2;
  logic [TW-1:0] inflight;
  logic          wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_we, issue_rd, wb_valid, wb_rd, flush,
    input  issue_ready, busy_rs1, busy_rs2, inflight, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_we, issue_rd, wb_valid, wb_rd, flush,
    output issue_ready, busy_rs1, busy_rs2, inflight, wb_err
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write counters for the RV32I pipeline.
//               Decode stalls while a used source has an outstanding write;
//               writeback retires entries. x0 is never tracked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNTW  = 2,
  parameter int TW    = 7
) (
  input  wire logic       clk,
  input  wire logic       rst,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};
  localparam logic [AW-1:0]   C_X0      = '0;

  logic [NREGS-1:0][CNTW-1:0] r_cnt;
  logic [TW-1:0]              r_inflight;
  logic                       r_wb_err;

  logic             w_busy_rs1;
  logic             w_busy_rs2;
  logic             w_rd_full;
  logic             w_ready;
  logic             w_inc;
  logic             w_dec;
  logic             w_wb_miss;
  logic [NREGS-1:0] w_inc_sel;
  logic [NREGS-1:0] w_dec_sel;

  // Hazard detection and issue/retire qualification from registered counts only
  always_comb begin
    w_busy_rs1 = (sb.issue_rs1 != C_X0) && (r_cnt[sb.issue_rs1] != '0);
    w_busy_rs2 = (sb.issue_rs2 != C_X0) && (r_cnt[sb.issue_rs2] != '0);
    w_rd_full  = sb.issue_we && (sb.issue_rd != C_X0) && (r_cnt[sb.issue_rd] == C_CNT_MAX);
    w_ready    = !(sb.issue_use_rs1 && w_busy_rs1) &&
                 !(sb.issue_use_rs2 && w_busy_rs2) &&
                 !w_rd_full;
    w_inc      = sb.issue_valid && w_ready && sb.issue_we && (sb.issue_rd != C_X0);
    w_dec      = sb.wb_valid && (sb.wb_rd != C_X0) && (r_cnt[sb.wb_rd] != '0);
    w_wb_miss  = sb.wb_valid && (sb.wb_rd != C_X0) && (r_cnt[sb.wb_rd] == '0);
  end

  // One-hot select of the register being incremented and the one being retired
  always_comb begin
    w_inc_sel = '0;
    w_dec_sel = '0;
    if (w_inc) w_inc_sel[sb.issue_rd] = 1'b1;
    if (w_dec) w_dec_sel[sb.wb_rd]    = 1'b1;
  end

  // Per-register counters; an inc and dec on the same register cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (sb.flush) begin
      r_cnt <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_inc_sel[r] && !w_dec_sel[r]) begin
          r_cnt[r] <= r_cnt[r] + CNTW'(1);
        end else if (w_dec_sel[r] && !w_inc_sel[r]) begin
          r_cnt[r] <= r_cnt[r] - CNTW'(1);
        end
      end
    end
  end

  // Total in-flight count; unchanged when an issue and a retire coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (sb.flush) begin
      r_inflight <= '0;
    end else if (w_inc && !w_dec) begin
      r_inflight <= r_inflight + TW'(1);
    end else if (w_dec && !w_inc) begin
      r_inflight <= r_inflight - TW'(1);
    end
  end

  // Sticky flag for a writeback with nothing pending; a flush cycle never sets it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_err <= 1'b0;
    end else if (!sb.flush && w_wb_miss) begin
      r_wb_err <= 1'b1;
    end
  end

  assign sb.issue_ready = w_ready;
  assign sb.busy_rs1    = w_busy_rs1;
  assign sb.busy_rs2    = w_busy_rs2;
  assign sb.inflight    = r_inflight;
  assign sb.wb_err      = r_wb_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed self-checking bench for reg_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  reg_scoreboard_if #(.AW(5), .TW(7)) bus ();

  reg_scoreboard #(.NREGS(32), .AW(5), .CNTW(2), .TW(7)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_rs1     = '0;
    bus.issue_rs2     = '0;
    bus.issue_use_rs1 = 1'b0;
    bus.issue_use_rs2 = 1'b0;
    bus.issue_we      = 1'b0;
    bus.issue_rd      = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = rd;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
  endtask

  // advance past the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after input changes
  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    // reset state
    bus.issue_rs1 = 5'd5;
    bus.issue_use_rs1 = 1'b1;
    settle();
    check("rst_inflight", 32'(bus.inflight), 32'd0);
    check("rst_wb_err",   32'(bus.wb_err),   32'd0);
    check("rst_ready",    32'(bus.issue_ready), 32'd1);
    check("rst_busy1",    32'(bus.busy_rs1), 32'd0);
    rst = 1'b0;
    idle();
    cyc();

    // 1. issue write to x5, then a reader of x5 stalls
    issue_wr(5'd5);
    settle();
    check("t1_ready_wr5", 32'(bus.issue_ready), 32'd1);
    cyc();
    idle();
    bus.issue_valid = 1'b1; bus.issue_use_rs1 = 1'b1; bus.issue_rs1 = 5'd5;
    settle();
    check("t1_inflight", 32'(bus.inflight), 32'd1);
    check("t1_busy1",    32'(bus.busy_rs1), 32'd1);
    check("t1_stall",    32'(bus.issue_ready), 32'd0);

    // 2. writeback in the stalled cycle: no bypass, clears next cycle
    wb(5'd5);
    settle();
    check("t2_no_bypass", 32'(bus.issue_ready), 32'd0);
    cyc();
    bus.wb_valid = 1'b0;
    settle();
    check("t2_ready",    32'(bus.issue_ready), 32'd1);
    check("t2_busy1",    32'(bus.busy_rs1), 32'd0);
    check("t2_inflight", 32'(bus.inflight), 32'd0);
    check("t2_wb_err",   32'(bus.wb_err), 32'd0);
    idle();

    // 3. saturate x7 at three in-flight writes
    issue_wr(5'd7);
    cyc();
    cyc();
    settle();
    check("t3_ready_third", 32'(bus.issue_ready), 32'd1);
    cyc();
    settle();
    check("t3_inflight3", 32'(bus.inflight), 32'd3);
    check("t3_sat_stall", 32'(bus.issue_ready), 32'd0);
    wb(5'd7);
    settle();
    check("t3_sat_no_bypass", 32'(bus.issue_ready), 32'd0);
    cyc();
    idle();
    bus.issue_we = 1'b1; bus.issue_rd = 5'd7;
    settle();
    check("t3_inflight2", 32'(bus.inflight), 32'd2);
    check("t3_ready_after", 32'(bus.issue_ready), 32'd1);
    idle();
    wb(5'd7);
    cyc();
    cyc();
    idle();
    settle();
    check("t3_drained", 32'(bus.inflight), 32'd0);

    // 4. simultaneous issue and writeback on the same register
    issue_wr(5'd9);
    cyc();
    wb(5'd9);
    cyc();
    idle();
    bus.issue_rs1 = 5'd9;
    settle();
    check("t4_inflight_same", 32'(bus.inflight), 32'd1);
    check("t4_busy9", 32'(bus.busy_rs1), 32'd1);
    check("t4_busy_x0", 32'(bus.busy_rs2), 32'd0);
    issue_wr(5'd0);
    cyc();
    idle();
    settle();
    check("t4_rd0_ignored", 32'(bus.inflight), 32'd1);
    wb(5'd9);
    cyc();
    idle();
    settle();
    check("t4_drained", 32'(bus.inflight), 32'd0);

    // 5. counts on x3, x4, x10 (with inc/dec on different regs), then flush
    issue_wr(5'd3);
    cyc();
    issue_wr(5'd4);
    cyc();
    issue_wr(5'd10);
    wb(5'd3);
    cyc();
    idle();
    bus.issue_rs1 = 5'd3; bus.issue_rs2 = 5'd10;
    settle();
    check("t5_inflight_diff", 32'(bus.inflight), 32'd2);
    check("t5_busy3", 32'(bus.busy_rs1), 32'd0);
    check("t5_busy10", 32'(bus.busy_rs2), 32'd1);
    issue_wr(5'd3);
    cyc();
    idle();
    settle();
    check("t5_inflight3", 32'(bus.inflight), 32'd3);
    issue_wr(5'd11);
    wb(5'd3);
    bus.flush = 1'b1;
    cyc();
    idle();
    bus.issue_rs1 = 5'd11; bus.issue_rs2 = 5'd4;
    settle();
    check("t5_flush_inflight", 32'(bus.inflight), 32'd0);
    check("t5_flush_busy11", 32'(bus.busy_rs1), 32'd0);
    check("t5_flush_busy4", 32'(bus.busy_rs2), 32'd0);
    check("t5_flush_wb_err", 32'(bus.wb_err), 32'd0);
    idle();

    // 6. writeback with nothing pending, x0 writeback, flush holds the flag, reset
    wb(5'd12);
    cyc();
    idle();
    settle();
    check("t6_wb_err_set", 32'(bus.wb_err), 32'd1);
    check("t6_inflight", 32'(bus.inflight), 32'd0);
    wb(5'd0);
    cyc();
    idle();
    bus.flush = 1'b1;
    cyc();
    idle();
    settle();
    check("t6_wb_err_held", 32'(bus.wb_err), 32'd1);
    issue_wr(5'd6);
    cyc();
    idle();
    bus.issue_rs1 = 5'd6; bus.issue_use_rs1 = 1'b1;
    settle();
    check("t6_busy6", 32'(bus.busy_rs1), 32'd1);
    rst = 1'b1;
    settle();
    check("t6_rst_inflight", 32'(bus.inflight), 32'd0);
    check("t6_rst_wb_err", 32'(bus.wb_err), 32'd0);
    check("t6_rst_busy6", 32'(bus.busy_rs1), 32'd0);
    check("t6_rst_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    rst = 1'b0;
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
